// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared state type and default width for the nibble serial adder
package nibble_serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIBBLES_DEFAULT = 4;

endpackage

// File: rtl/nibble_shreg.sv
// rtl/nibble_shreg.sv - loadable register shifting right one nibble per step, low nibble exposed
module nibble_shreg #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         shift,
   input  logic [3:0]   nib_in,
   output logic [W-1:0] q,
   output logic [3:0]   low
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= din;
      end else if (shift) begin
         q <= {nib_in, q[W-1:4]};
      end
   end

   assign low = q[3:0];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - W-bit adder that time-multiplexes an external 4-bit adder one nibble per cycle
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int NIBBLES = NIBBLES_DEFAULT,
   parameter int W       = 4 * NIBBLES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_cin,
   output logic [3:0]   add_a,
   output logic [3:0]   add_b,
   output logic         add_cin,
   input  logic [3:0]   add_sum,
   input  logic         add_cout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_cout,
   output logic         out_ovf
);

   localparam int IW = $clog2(NIBBLES);

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q;
   logic          carry_q, cout_q, ovf_q;
   logic          accept, step, last;
   logic [W-1:0]  a_q, b_q;
   logic [3:0]    a_low, b_low, res_low;
   logic          unused_bits;

   assign last = (idx_q == IW'(NIBBLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      step      = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The external adder is combinational, so its result is captured on the same edge it is presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         idx_q   <= '0;
         carry_q <= in_cin;
      end else if (step) begin
         idx_q   <= idx_q + IW'(1);
         carry_q <= add_cout;
         if (last) begin
            cout_q <= add_cout;
            ovf_q  <= add_a[3] ^ add_b[3] ^ add_sum[3] ^ add_cout;
         end
      end
   end

   nibble_shreg #(.W(W)) u_a (
      .clk(clk), .rst(rst), .load(accept), .din(in_a), .shift(step),
      .nib_in(4'h0), .q(a_q), .low(a_low)
   );

   nibble_shreg #(.W(W)) u_b (
      .clk(clk), .rst(rst), .load(accept), .din(in_b), .shift(step),
      .nib_in(4'h0), .q(b_q), .low(b_low)
   );

   // Sum nibbles enter at the top so the first one lands at bit 0 after NIBBLES shifts.
   nibble_shreg #(.W(W)) u_res (
      .clk(clk), .rst(rst), .load(1'b0), .din('0), .shift(step),
      .nib_in(add_sum), .q(out_sum), .low(res_low)
   );

   assign add_a    = step ? a_low : 4'h0;
   assign add_b    = step ? b_low : 4'h0;
   assign add_cin  = step ? carry_q : 1'b0;
   assign out_cout = cout_q;
   assign out_ovf  = ovf_q;

   assign unused_bits = ^{a_q[W-1:4], b_q[W-1:4], res_low};

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed and random self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_cin = 1'b0;
   logic [3:0]   add_a, add_b, add_sum;
   logic         add_cin, add_cout;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_sum;
   logic         out_cout, out_ovf;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int lat;
   logic [3:0] cins;
   logic mon_en = 1'b0;
   logic [W+1:0] expq[$];

   nibble_serial_adder #(.NIBBLES(N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
   );

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [W:0]   full;
      logic         ovf;
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
      return {full[W], ovf, full[W-1:0]};
   endfunction

   // Entered and left on a negedge; returns once out_valid is seen or the bound expires.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      check("accept_ready", {31'd0, in_ready}, 32'd1);
      in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      cins = 4'h0;
      while (!out_valid && lat < 20) begin
         if (lat < 4) cins[lat] = add_cin;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                               input logic [W-1:0] es, input logic ec, input logic eo);
      start_op(a, b, c);
      check({tag, "_lat"}, lat, N);
      check({tag, "_sum"}, {16'd0, out_sum}, {16'd0, es});
      check({tag, "_cout"}, {31'd0, out_cout}, {31'd0, ec});
      check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
   endtask

   task automatic finish_op(input string tag, input logic [W-1:0] es);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_vdrop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_hold"}, {16'd0, out_sum}, {16'd0, es});
      check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
   endtask

   always @(negedge clk) begin
      if (mon_en && out_valid && out_ready) begin
         if (expq.size() == 0) begin
            check("stream_extra", 32'd1, 32'd0);
         end else begin
            check("stream_res", {14'd0, out_cout, out_ovf, out_sum}, {14'd0, expq.pop_front()});
         end
      end
   end

   initial begin
      int last_t;
      int guard;
      logic [W-1:0] ra, rb;
      logic rc;

      @(negedge clk);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      check("rst_outs", {12'd0, out_valid, out_cout, out_ovf, out_sum, add_a, add_b, add_cin},
            32'd0);
      rst = 1'b0;
      @(negedge clk);

      check_result("wrap", 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0);
      check("wrap_cins", {28'd0, cins}, 32'hE);
      finish_op("wrap", 16'h0000);

      check_result("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      finish_op("posovf", 16'h8000);

      check_result("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      finish_op("negovf", 16'h0000);

      check_result("cin", 16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0);
      check("cin_seq", {28'd0, cins}, 32'hF);
      finish_op("cin", 16'h1001);

      // Backpressure: stalled result must hold while new requests are ignored
      check_result("bp", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b1;
         @(negedge clk);
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_sum", {16'd0, out_sum}, 32'h1000);
         check("bp_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      finish_op("bp", 16'h1000);
      @(negedge clk);
      check("bp_noop", {31'd0, in_ready}, 32'd1);

      // Reset two cycles into RUN aborts the operation
      in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_ready", {31'd0, in_ready}, 32'd1);
      check("abort_outs", {12'd0, out_valid, out_cout, out_ovf, out_sum, add_a, add_b, add_cin},
            32'd0);
      @(negedge clk);
      rst = 1'b0;
      check_result("post_rst", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      finish_op("post_rst", 16'h5555);

      // Random back-to-back stream
      out_ready = 1'b1;
      mon_en = 1'b1;
      last_t = 0;
      for (int i = 0; i < 1000; i++) begin
         guard = 0;
         while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 50) check("stream_timeout", 32'd1, 32'd0);
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         in_a = ra; in_b = rb; in_cin = rc; in_valid = 1'b1;
         expq.push_back(model(ra, rb, rc));
         if (i > 0) check("stream_gap", cyc - last_t, N + 2);
         last_t = cyc;
         @(negedge clk);
      end
      in_valid = 1'b0;
      guard = 0;
      while (expq.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("stream_drain", expq.size(), 32'd0);
      mon_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
